mem_port_arbiter: RTL and testbench

//  Shares one single-port memory (unified BRAM) between the instruction-fetch path and the

---
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_port_arbiter                                           |
// | Description : Shares one single-port memory between instruction fetch    |
// |               and load/store, data-priority with fetch anti-starvation.  |
// |               Optional macro ARB_PERF_CNT_EN adds per-port stall counters.|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      if_req,
    input  logic [ADDR_WIDTH-1:0]     if_addr,
    output logic                      if_gnt,
    output logic                      if_rvalid,
    output logic [DATA_WIDTH-1:0]     if_rdata,
    input  logic                      dm_req,
    input  logic                      dm_we,
    input  logic [DATA_WIDTH/8-1:0]   dm_be,
    input  logic [ADDR_WIDTH-1:0]     dm_addr,
    input  logic [DATA_WIDTH-1:0]     dm_wdata,
    output logic                      dm_gnt,
    output logic                      dm_rvalid,
    output logic [DATA_WIDTH-1:0]     dm_rdata,
    output logic                      mem_en,
    output logic [DATA_WIDTH/8-1:0]   mem_we,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic                      busy
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]               perf_if_stall,
    output logic [31:0]               perf_dm_stall
`endif
);

    localparam logic [1:0] c_LAT_LAST   = 2'(MEM_LATENCY - 1);
    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [0:0] c_ST_IDLE    = 1'b0;
    localparam logic [0:0] c_ST_WAIT    = 1'b1;

    logic [0:0]            r_state;
    logic [1:0]            r_wait_cnt;
    logic [3:0]            r_starve_cnt;
    logic                  r_owner_dm;
    logic                  r_op_wr;
    logic                  r_if_rvalid;
    logic                  r_dm_rvalid;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic [DATA_WIDTH-1:0] r_dm_rdata;

    logic w_idle;
    logic w_starved;
    logic w_dm_win;
    logic w_if_win;

    // Grant is combinational in IDLE; rst gates it so nothing issues during reset.
    assign w_idle    = (r_state == c_ST_IDLE) && !rst;
    assign w_starved = (r_starve_cnt == c_STARVE_MAX);
    assign w_dm_win  = w_idle && dm_req && !(if_req && w_starved);
    assign w_if_win  = w_idle && if_req && !w_dm_win;

    assign if_gnt    = w_if_win;
    assign dm_gnt    = w_dm_win;
    assign mem_en    = w_if_win | w_dm_win;
    assign mem_we    = (w_dm_win && dm_we) ? dm_be : '0;
    assign mem_addr  = w_dm_win ? dm_addr : (w_if_win ? if_addr : '0);
    assign mem_wdata = w_dm_win ? dm_wdata : '0;
    assign busy      = (r_state != c_ST_IDLE);
    assign if_rvalid = r_if_rvalid;
    assign if_rdata  = r_if_rdata;
    assign dm_rvalid = r_dm_rvalid;
    assign dm_rdata  = r_dm_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_wait_cnt   <= '0;
            r_starve_cnt <= '0;
            r_owner_dm   <= 1'b0;
            r_op_wr      <= 1'b0;
            r_if_rvalid  <= 1'b0;
            r_dm_rvalid  <= 1'b0;
            r_if_rdata   <= '0;
            r_dm_rdata   <= '0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_dm_rvalid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_wait_cnt <= '0;
                    if (!if_req || w_if_win) begin
                        r_starve_cnt <= '0;
                    end else if (w_dm_win && !w_starved) begin
                        r_starve_cnt <= r_starve_cnt + 4'd1;
                    end
                    if (w_if_win || w_dm_win) begin
                        r_state    <= c_ST_WAIT;
                        r_owner_dm <= w_dm_win;
                        r_op_wr    <= w_dm_win && dm_we;
                    end
                end
                c_ST_WAIT: begin
                    if (r_wait_cnt == c_LAT_LAST) begin
                        r_state    <= c_ST_IDLE;
                        r_wait_cnt <= '0;
                        if (r_owner_dm) begin
                            r_dm_rvalid <= 1'b1;
                            r_dm_rdata  <= r_op_wr ? '0 : mem_rdata;
                        end else begin
                            r_if_rvalid <= 1'b1;
                            r_if_rdata  <= mem_rdata;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 2'd1;
                    end
                end
            endcase
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0] r_perf_if;
    logic [31:0] r_perf_dm;

    assign perf_if_stall = r_perf_if;
    assign perf_dm_stall = r_perf_dm;

    // Stall = request high without a grant in the same cycle, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_if <= '0;
            r_perf_dm <= '0;
        end else begin
            if (if_req && !w_if_win && (r_perf_if != 32'hFFFF_FFFF)) begin
                r_perf_if <= r_perf_if + 32'd1;
            end
            if (dm_req && !w_dm_win && (r_perf_dm != 32'hFFFF_FFFF)) begin
                r_perf_dm <= r_perf_dm + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mem_port_arbiter                                        |
// | Description : Self-checking bench for mem_port_arbiter (reference model  |
// |               plus directed checks; honours ARB_PERF_CNT_EN).            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mem_port_arbiter;

    localparam int LAT   = 1;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [3:0]  dm_be, mem_we;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_en, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        x_if_req, x_if_gnt, x_if_rvalid, x_dm_gnt, x_dm_rvalid;
    logic [31:0] x_if_addr, x_if_rdata, x_dm_rdata;
    logic        x_mem_en, x_busy;
    logic [3:0]  x_mem_we;
    logic [31:0] x_mem_addr, x_mem_wdata, x_mem_rdata;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_stall, perf_dm_stall, x_perf_if, x_perf_dm;
`endif

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(LAT), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
`ifdef ARB_PERF_CNT_EN
        , .perf_if_stall(perf_if_stall), .perf_dm_stall(perf_dm_stall)
`endif
    );

    // Second instance with latency 3, fetch-only traffic.
    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(3), .STARVE_LIMIT(LIMIT)) dut3 (
        .clk(clk), .rst(rst),
        .if_req(x_if_req), .if_addr(x_if_addr), .if_gnt(x_if_gnt), .if_rvalid(x_if_rvalid), .if_rdata(x_if_rdata),
        .dm_req(1'b0), .dm_we(1'b0), .dm_be(4'b0), .dm_addr(32'b0), .dm_wdata(32'b0),
        .dm_gnt(x_dm_gnt), .dm_rvalid(x_dm_rvalid), .dm_rdata(x_dm_rdata),
        .mem_en(x_mem_en), .mem_we(x_mem_we), .mem_addr(x_mem_addr), .mem_wdata(x_mem_wdata),
        .mem_rdata(x_mem_rdata), .busy(x_busy)
`ifdef ARB_PERF_CNT_EN
        , .perf_if_stall(x_perf_if), .perf_dm_stall(x_perf_dm)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 60) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pat(input int i);
        return (i == 64) ? 32'hDEADBEEF : (32'h1000_0000 + 32'(i) * 32'h0001_0203);
    endfunction

    function automatic logic [31:0] rom2(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory environments: one-stage for the main instance, three-stage ROM for the other.
    logic [31:0] env1 [0:255];
    logic [31:0] rd1;
    logic [31:0] p1, p2, p3;
    assign mem_rdata   = rd1;
    assign x_mem_rdata = p3;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) env1[i] <= pat(i);
            rd1 <= 32'h0;
        end else if (mem_en) begin
            rd1 <= env1[mem_addr[9:2]];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) env1[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    always @(posedge clk) begin
        p1 <= x_mem_en ? rom2(x_mem_addr) : 32'h0;
        p2 <= p1;
        p3 <= p2;
    end

    // Reference model state: a transaction issued in cycle c frees the port and
    // delivers its response in cycle c+LAT+1.
    int          cyc = 0;
    int          m_free_at = 0;
    int          m_resp_at = -1;
    bit          m_resp_dm;
    logic [31:0] m_resp_data;
    int          m_starve = 0;
    logic [31:0] shadow [0:255];
    bit          m_if_gnt_now = 1'b0;
    bit          m_dm_gnt_now = 1'b0;
    logic [31:0] m_pif = 0, m_pdm = 0;
    bit          t5_on = 1'b0;
    int          t5_cyc = 0;

    always @(negedge clk) begin : cmp
        bit free, eif, edm, eirv, edrv;
        logic [31:0] a;
        int idx;
        cyc++;
        eif = 0; edm = 0; eirv = 0; edrv = 0; free = 1;
        if (rst) begin
            m_free_at = cyc;
            m_resp_at = -1;
            m_starve  = 0;
            m_pif     = 0;
            m_pdm     = 0;
            for (int i = 0; i < 256; i++) shadow[i] = pat(i);
        end else begin
            free = (cyc >= m_free_at);
            eirv = (cyc == m_resp_at) && !m_resp_dm;
            edrv = (cyc == m_resp_at) && m_resp_dm;
            if (free) begin
                if (dm_req && if_req) begin
                    if (m_starve == LIMIT) eif = 1; else edm = 1;
                end else if (dm_req) edm = 1;
                else if (if_req) eif = 1;
                if (!if_req || eif) m_starve = 0;
                else if (edm && m_starve < LIMIT) m_starve++;
            end
        end
        chk("if_gnt", if_gnt, eif);
        chk("dm_gnt", dm_gnt, edm);
        chk("mem_en", mem_en, eif | edm);
        chk("busy", busy, !rst && !free);
        chk("if_rvalid", if_rvalid, eirv);
        chk("dm_rvalid", dm_rvalid, edrv);
        if (eirv) chk("if_rdata", if_rdata, m_resp_data);
        if (edrv) chk("dm_rdata", dm_rdata, m_resp_data);
        if (eif || edm) begin
            a = edm ? dm_addr : if_addr;
            idx = int'(a[9:2]);
            chk("mem_addr", mem_addr, a);
            chk("mem_we", mem_we, (edm && dm_we) ? {28'b0, dm_be} : 32'b0);
            if (edm) chk("mem_wdata", mem_wdata, dm_wdata);
            m_resp_data = (edm && dm_we) ? 32'h0 : shadow[idx];
            if (edm && dm_we)
                for (int b = 0; b < 4; b++)
                    if (dm_be[b]) shadow[idx][8*b +: 8] = dm_wdata[8*b +: 8];
            m_resp_dm = edm;
            m_resp_at = cyc + LAT + 1;
            m_free_at = cyc + LAT + 1;
        end
`ifdef ARB_PERF_CNT_EN
        chk("perf_if_stall", perf_if_stall, m_pif);
        chk("perf_dm_stall", perf_dm_stall, m_pdm);
        if (!rst) begin
            if (if_req && !eif && m_pif != 32'hFFFF_FFFF) m_pif++;
            if (dm_req && !edm && m_pdm != 32'hFFFF_FFFF) m_pdm++;
        end
`endif
        m_if_gnt_now = eif;
        m_dm_gnt_now = edm;
        if (t5_on) begin
            chk("t5_if_gnt", x_if_gnt, 32'(t5_cyc % 4 == 0));
            chk("t5_if_rvalid", x_if_rvalid, 32'((t5_cyc % 4 == 0) && (t5_cyc > 0)));
            if ((t5_cyc % 4 == 0) && (t5_cyc > 0))
                chk("t5_if_rdata", x_if_rdata, rom2(32'(4 * (t5_cyc / 4 - 1))));
            if (t5_cyc % 4 == 0) chk("t5_mem_addr", x_mem_addr, 32'(4 * (t5_cyc / 4)));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Raises a data request and returns at negedge+1 of the model's grant cycle.
    task automatic issue_dm(input logic we, input logic [3:0] be, input logic [31:0] addr,
                            input logic [31:0] wdata);
        int ok;
        @(posedge clk); #1;
        dm_req = 1'b1; dm_we = we; dm_be = be; dm_addr = addr; dm_wdata = wdata;
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #1;
            if (m_dm_gnt_now) begin ok = 1; break; end
        end
        chk("dm_grant_within_bound", 32'(ok), 32'd1);
    endtask

    logic [31:0] pi0, pd0, pi1, pd1;
    int          seq [0:9];
    int          ngr;

    initial begin
        if_req = 1'b1; if_addr = 32'h40;
        dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'b0; dm_addr = 32'h0; dm_wdata = 32'h0;
        x_if_req = 1'b0; x_if_addr = 32'h0;
        pi0 = 0; pd0 = 0; pi1 = 0; pd1 = 0;

        // Reset with a fetch pending: nothing issues until rst falls.
        repeat (3) begin
            @(negedge clk); #1;
            chk("t1_rst_if_gnt", if_gnt, 0);
            chk("t1_rst_mem_en", mem_en, 0);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk); #1 chk("t1_first_gnt", if_gnt, 1);
        @(posedge clk); #1 if_req = 1'b0;
        idle(4);

        // Latency-3 back-to-back fetches on the second instance.
        for (int c = 0; c < 24; c++) begin
            @(posedge clk); #1;
            x_if_req = 1'b1; x_if_addr = 32'(4 * (c / 4)); t5_cyc = c; t5_on = 1'b1;
        end
        @(posedge clk); #1 t5_on = 1'b0; x_if_req = 1'b0;
        idle(6);

        // Load from 0x100.
        issue_dm(1'b0, 4'b0000, 32'h100, 32'h0);
        chk("t2_gnt_T", dm_gnt, 1);
        @(posedge clk); #1 dm_req = 1'b0;
        @(negedge clk); #1 chk("t2_rvalid_T1", dm_rvalid, 0);
        @(negedge clk); #1 chk("t2_rvalid_T2", dm_rvalid, 1);
        chk("t2_rdata", dm_rdata, 32'hDEADBEEF);

        // Partial store to 0x104, then read it back through the model.
        issue_dm(1'b1, 4'b0011, 32'h104, 32'h12345678);
        chk("t3_mem_we", mem_we, 32'h3);
        chk("t3_mem_wdata", mem_wdata, 32'h12345678);
        @(posedge clk); #1 dm_req = 1'b0;
        @(negedge clk); #1;
        @(negedge clk); #1 chk("t3_rvalid", dm_rvalid, 1);
        chk("t3_rdata_zero", dm_rdata, 0);
        issue_dm(1'b0, 4'b0000, 32'h104, 32'h0);
        @(posedge clk); #1 dm_req = 1'b0;
        @(negedge clk); #1;
        @(negedge clk); #1 chk("t3_readback", dm_rdata, (pat(65) & 32'hFFFF_0000) | 32'h0000_5678);
        idle(3);

        // Both requesters held: starvation guard yields the fetch every fifth grant.
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h80; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
        ngr = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
`ifdef ARB_PERF_CNT_EN
            if (c == 0) begin pi0 = perf_if_stall; pd0 = perf_dm_stall; end
            if (c == 10) begin pi1 = perf_if_stall; pd1 = perf_dm_stall; end
`endif
            if (dm_gnt || if_gnt) begin
                if (ngr < 10) seq[ngr] = int'(if_gnt);
                ngr++;
            end
        end
        @(posedge clk); #1 if_req = 1'b0; dm_req = 1'b0;
        chk("t4_grant_count", 32'(ngr), 32'd10);
        for (int k = 0; k < 10; k++) chk("t4_grant_seq", 32'(seq[k]), 32'(k % 5 == 4));
`ifdef ARB_PERF_CNT_EN
        chk("t7_if_stall", pi1 - pi0, 32'd9);
        chk("t7_dm_stall", pd1 - pd0, 32'd6);
`endif
        idle(4);

        // Reset right after a data grant: the response is abandoned.
        issue_dm(1'b0, 4'b0000, 32'h10, 32'h0);
        @(posedge clk); #1 rst = 1'b1; dm_req = 1'b0;
        @(negedge clk); #1 chk("t6_rvalid_in_rst", dm_rvalid, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk); #1;
            chk("t6_no_rvalid", dm_rvalid, 0);
            chk("t6_busy", busy, 0);
        end
        issue_dm(1'b0, 4'b0000, 32'h100, 32'h0);
        @(posedge clk); #1 dm_req = 1'b0;
        @(negedge clk); #1;
        @(negedge clk); #1 chk("t6_after_rst_rvalid", dm_rvalid, 1);
        chk("t6_after_rst_rdata", dm_rdata, 32'hDEADBEEF);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            @(posedge clk); #1;
            if (!if_req || m_if_gnt_now) begin
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            end
            if (!dm_req || m_dm_gnt_now) begin
                dm_req   = ($urandom_range(0, 2) != 0);
                dm_we    = 1'($urandom_range(0, 1));
                dm_be    = 4'($urandom);
                dm_addr  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
                dm_wdata = $urandom;
            end
        end
        @(posedge clk); #1 if_req = 1'b0; dm_req = 1'b0;
        idle(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
